// File: rtl/sam_video_addr.sv
// Display address generator and memory reader that feeds the VDG Data input.
// Optional build macro VADDR_RP_SYNC_EN locks the mode-000 row repeat to RPn.
module sam_video_addr #(
    parameter int ADDR_W     = 16,
    parameter int BASE_SHIFT = 9
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              DA0,
    input  logic              HSn,
    input  logic              FSn,
    input  logic              RPn,
    input  logic [6:0]        Base,
    input  logic [2:0]        VMode,
    input  logic              MemAck,
    input  logic [7:0]        MemData,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [7:0]        VidData,
    output logic              Overrun
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t state_q, state_d;

    logic              da0_q, hs_q, rise, hfall;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_step, linestart_q, linestart_d, base_addr;
    logic [1:0]        xcnt_q, xcnt_d, x_max;
    logic [3:0]        rowcnt_q, rowcnt_d, y_max;
    logic [2:0]        vmode_q, vmode_d;
    logic              fetch, row_sync, load_addr, load_data, set_overrun;

    assign rise      = DA0 & ~da0_q;
    assign hfall     = ~HSn & hs_q;
    assign base_addr = ADDR_W'(Base) << BASE_SHIFT;
    assign fetch     = FSn & rise & (xcnt_q == 2'd0);
    assign MemReq    = (state_q == REQ);

`ifdef VADDR_RP_SYNC_EN
    assign row_sync = RPn & (vmode_q == 3'b000);
`else
    logic rp_unused;
    assign rp_unused = RPn;
    assign row_sync  = 1'b0;
`endif

    // Terminal counts (X-1, Y-1) for the mode latched at the last hfall or frame sync.
    always_comb begin
        x_max = 2'd0;
        y_max = 4'd0;
        case (vmode_q)
            3'b000: y_max = 4'd11;
            3'b001: begin x_max = 2'd2; y_max = 4'd2; end
            3'b010: y_max = 4'd2;
            3'b011: begin x_max = 2'd1; y_max = 4'd1; end
            3'b100: y_max = 4'd1;
            default: ;
        endcase
    end

    // A same-cycle rise is applied first so the line rule sees the stepped address.
    always_comb begin
        addr_step   = addr_q;
        addr_d      = addr_q;
        linestart_d = linestart_q;
        xcnt_d      = xcnt_q;
        rowcnt_d    = rowcnt_q;
        vmode_d     = vmode_q;
        if (!FSn) begin
            addr_d      = base_addr;
            linestart_d = base_addr;
            xcnt_d      = 2'd0;
            rowcnt_d    = 4'd0;
            vmode_d     = VMode;
        end else begin
            if (rise) begin
                if (xcnt_q >= x_max) begin
                    xcnt_d    = 2'd0;
                    addr_step = addr_q + ADDR_W'(1);
                end else begin
                    xcnt_d = xcnt_q + 2'd1;
                end
            end
            addr_d = addr_step;
            if (hfall) begin
                xcnt_d  = 2'd0;
                vmode_d = VMode;
                if (row_sync || rowcnt_q >= y_max) begin
                    linestart_d = addr_step;
                    rowcnt_d    = 4'd0;
                end else begin
                    addr_d   = linestart_q;
                    rowcnt_d = rowcnt_q + 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        load_addr   = 1'b0;
        load_data   = 1'b0;
        set_overrun = 1'b0;
        case (state_q)
            IDLE: if (fetch) begin
                state_d   = REQ;
                load_addr = 1'b1;
            end
            REQ: begin
                set_overrun = fetch;
                if (MemAck) begin
                    state_d   = IDLE;
                    load_data = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            da0_q       <= 1'b0;
            hs_q        <= 1'b0;
            addr_q      <= '0;
            linestart_q <= '0;
            xcnt_q      <= '0;
            rowcnt_q    <= '0;
            vmode_q     <= '0;
        end else begin
            da0_q       <= DA0;
            hs_q        <= HSn;
            addr_q      <= addr_d;
            linestart_q <= linestart_d;
            xcnt_q      <= xcnt_d;
            rowcnt_q    <= rowcnt_d;
            vmode_q     <= vmode_d;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A request in flight completes even across frame sync; Overrun is sticky until FSn low.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            MemAddr <= '0;
            VidData <= 8'h00;
            Overrun <= 1'b0;
        end else begin
            if (load_addr) MemAddr <= addr_q;
            if (load_data) VidData <= MemData;
            if (!FSn)             Overrun <= 1'b0;
            else if (set_overrun) Overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sam_video_addr.sv
// Bench for sam_video_addr: fixed vector table, directed line/frame sequences and a
// random run against a slot-counting reference model.
module tb_sam_video_addr;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        da0, hsn, fsn, rpn, mem_ack;
    logic [6:0]  base;
    logic [2:0]  vmode;
    logic [7:0]  mem_data;
    logic        MemReq, Overrun;
    logic [15:0] MemAddr;
    logic [7:0]  VidData;

    always #5 Clk = ~Clk;

    sam_video_addr #(.ADDR_W(16), .BASE_SHIFT(9)) dut (
        .Clk(Clk), .Reset(Reset), .DA0(da0), .HSn(hsn), .FSn(fsn), .RPn(rpn),
        .Base(base), .VMode(vmode), .MemAck(mem_ack), .MemData(mem_data),
        .MemReq(MemReq), .MemAddr(MemAddr), .VidData(VidData), .Overrun(Overrun)
    );

`ifdef VADDR_RP_SYNC_EN
    localparam bit RP_SYNC = 1'b1;
`else
    localparam bit RP_SYNC = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    // Reference: the line is described by its start address and the number of slots seen.
    logic        m_da0, m_hs, m_req, m_ovr;
    logic [15:0] m_ls, m_addr;
    logic [7:0]  m_vid;
    logic [2:0]  m_mode;
    int          m_slots, m_row, req_age, ack_dly;
    logic [6:0]  cur_base;
    logic [2:0]  cur_vmode;
    logic        q_req;
    logic [15:0] q_addr;

    typedef struct {
        logic da0, hsn, fsn, rpn;
        logic [6:0] base; logic [2:0] vmode; logic ack; logic [7:0] data;
        logic exp_req; logic [15:0] exp_addr; logic [7:0] exp_vid; logic exp_ovr;
    } vec_t;
    vec_t vecs [18];

    function automatic int mode_x(input logic [2:0] m);
        case (m)
            3'b001:  return 3;
            3'b011:  return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int mode_y(input logic [2:0] m);
        case (m)
            3'b000:         return 12;
            3'b001, 3'b010: return 3;
            3'b011, 3'b100: return 2;
            default:        return 1;
        endcase
    endfunction

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[14:8], a[15]} ^ 8'h5A;
    endfunction

    function automatic void model_reset();
        m_da0 = 1'b0; m_hs = 1'b0; m_req = 1'b0; m_ovr = 1'b0;
        m_ls = 16'h0000; m_addr = 16'h0000; m_vid = 8'h00; m_mode = 3'b000;
        m_slots = 0; m_row = 0; req_age = 0;
    endfunction

    function automatic void model_step(input logic a_da0, a_hsn, a_fsn, a_rpn,
                                       input logic [6:0] a_base, input logic [2:0] a_vmode,
                                       input logic a_ack, input logic [7:0] a_data);
        bit rise, hf, fetch;
        logic [15:0] faddr, pos;
        rise = a_da0 && !m_da0;
        hf = !a_hsn && m_hs;
        m_da0 = a_da0; m_hs = a_hsn;
        fetch = 1'b0; faddr = 16'h0000;
        if (!a_fsn) begin
            m_ls = {a_base, 9'b0}; m_slots = 0; m_row = 0; m_mode = a_vmode; m_ovr = 1'b0;
        end else begin
            if (rise) begin
                if (m_slots % mode_x(m_mode) == 0) begin
                    fetch = 1'b1;
                    faddr = 16'(m_ls + 16'(m_slots / mode_x(m_mode)));
                end
                m_slots++;
            end
            if (hf) begin
                pos = 16'(m_ls + 16'(m_slots / mode_x(m_mode)));
                if ((RP_SYNC && a_rpn && m_mode == 3'b000) || m_row >= mode_y(m_mode) - 1) begin
                    m_ls = pos; m_row = 0;
                end else begin
                    m_row++;
                end
                m_slots = 0; m_mode = a_vmode;
            end
        end
        if (m_req) begin
            if (fetch) m_ovr = 1'b1;
            if (a_ack) begin m_vid = a_data; m_req = 1'b0; end
            else req_age++;
        end else if (fetch) begin
            m_req = 1'b1; m_addr = faddr; req_age = 0;
        end
    endfunction

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic e_req, input logic [15:0] e_addr,
                               input logic [7:0] e_vid, input logic e_ovr);
        check_val({tag, ".req"}, 16'(MemReq), 16'(e_req));
        check_val({tag, ".addr"}, MemAddr, e_addr);
        check_val({tag, ".vid"}, 16'(VidData), 16'(e_vid));
        check_val({tag, ".ovr"}, 16'(Overrun), 16'(e_ovr));
    endtask

    task automatic applyStimulus(input logic a_da0, a_hsn, a_fsn, a_rpn,
                                 input logic [6:0] a_base, input logic [2:0] a_vmode,
                                 input logic a_ack, input logic [7:0] a_data);
        da0 = a_da0; hsn = a_hsn; fsn = a_fsn; rpn = a_rpn;
        base = a_base; vmode = a_vmode; mem_ack = a_ack; mem_data = a_data;
        @(posedge Clk);
        model_step(a_da0, a_hsn, a_fsn, a_rpn, a_base, a_vmode, a_ack, a_data);
        #1;
    endtask

    // The bench acts as memory: it acks after ack_dly cycles and returns mem_byte(addr).
    task automatic mem_cycle(input logic a_da0, a_hsn, a_fsn, a_rpn);
        logic ack;
        logic [7:0] data;
        ack  = m_req && (req_age >= ack_dly);
        data = ack ? mem_byte(m_addr) : 8'($urandom);
        applyStimulus(a_da0, a_hsn, a_fsn, a_rpn, cur_base, cur_vmode, ack, data);
        checkOutput("model", m_req, m_addr, m_vid, m_ovr);
    endtask

    task automatic slot(input int gap, output logic s_req, output logic [15:0] s_addr);
        mem_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        s_req = MemReq; s_addr = MemAddr;
        for (int g = 0; g < gap; g++) mem_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic hsync(input logic a_rpn);
        mem_cycle(1'b0, 1'b0, 1'b1, a_rpn);
        mem_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        mem_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic frame(input logic [6:0] b, input logic [2:0] m);
        cur_base = b; cur_vmode = m;
        mem_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        mem_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,7'h02,3'b101,1'b0,8'h00, 1'b0,16'h0000,8'h00,1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,7'h02,3'b101,1'b0,8'h00, 1'b0,16'h0000,8'h00,1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,7'h02,3'b101,1'b0,8'h00, 1'b0,16'h0000,8'h00,1'b0};
        vecs[3]  = '{1'b1,1'b1,1'b1,1'b0,7'h02,3'b101,1'b0,8'h00, 1'b1,16'h0400,8'h00,1'b0};
        vecs[4]  = '{1'b1,1'b1,1'b1,1'b0,7'h02,3'b101,1'b1,8'hA5, 1'b0,16'h0400,8'hA5,1'b0};
        vecs[5]  = '{1'b0,1'b1,1'b1,1'b0,7'h02,3'b101,1'b0,8'h00, 1'b0,16'h0400,8'hA5,1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,7'h02,3'b101,1'b0,8'h00, 1'b1,16'h0401,8'hA5,1'b0};
        vecs[7]  = '{1'b1,1'b1,1'b1,1'b0,7'h02,3'b101,1'b0,8'h00, 1'b1,16'h0401,8'hA5,1'b0};
        vecs[8]  = '{1'b0,1'b1,1'b1,1'b0,7'h02,3'b101,1'b1,8'h3C, 1'b0,16'h0401,8'h3C,1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b1,1'b0,7'h02,3'b101,1'b0,8'h00, 1'b1,16'h0402,8'h3C,1'b0};
        vecs[10] = '{1'b1,1'b0,1'b1,1'b0,7'h02,3'b101,1'b1,8'h77, 1'b0,16'h0402,8'h77,1'b0};
        vecs[11] = '{1'b0,1'b1,1'b1,1'b0,7'h02,3'b101,1'b0,8'h00, 1'b0,16'h0402,8'h77,1'b0};
        vecs[12] = '{1'b1,1'b1,1'b1,1'b0,7'h02,3'b101,1'b0,8'h00, 1'b1,16'h0403,8'h77,1'b0};
        vecs[13] = '{1'b0,1'b1,1'b1,1'b0,7'h02,3'b101,1'b1,8'h11, 1'b0,16'h0403,8'h11,1'b0};
        vecs[14] = '{1'b1,1'b1,1'b1,1'b0,7'h02,3'b101,1'b0,8'h00, 1'b1,16'h0404,8'h11,1'b0};
        vecs[15] = '{1'b0,1'b1,1'b1,1'b0,7'h02,3'b101,1'b0,8'h00, 1'b1,16'h0404,8'h11,1'b0};
        vecs[16] = '{1'b1,1'b1,1'b1,1'b0,7'h02,3'b101,1'b0,8'h00, 1'b1,16'h0404,8'h11,1'b1};
        vecs[17] = '{1'b0,1'b1,1'b0,1'b0,7'h02,3'b101,1'b1,8'h22, 1'b0,16'h0404,8'h22,1'b0};

        Reset = 1'b1; da0 = 1'b0; hsn = 1'b1; fsn = 1'b1; rpn = 1'b0;
        base = 7'h00; vmode = 3'b000; mem_ack = 1'b0; mem_data = 8'h00;
        ack_dly = 0; cur_base = 7'h00; cur_vmode = 3'b000;
        model_reset();
        #1;
        checkOutput("reset", 1'b0, 16'h0000, 8'h00, 1'b0);
        #11;
        Reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].da0, vecs[i].hsn, vecs[i].fsn, vecs[i].rpn,
                          vecs[i].base, vecs[i].vmode, vecs[i].ack, vecs[i].data);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                        vecs[i].exp_vid, vecs[i].exp_ovr);
        end

        // One byte per slot: 32 fetches, then the next line carries on at 0x0420.
        frame(7'h02, 3'b101);
        for (int i = 0; i < 32; i++) begin
            slot(2, q_req, q_addr);
            if (i == 0) check_val("m5_first", q_addr, 16'h0400);
        end
        hsync(1'b0);
        slot(2, q_req, q_addr);
        check_val("m5_line2", q_addr, 16'h0420);

        // Three slots per byte, three scan lines per row.
        frame(7'h02, 3'b001);
        for (int ln = 1; ln <= 4; ln++) begin
            for (int i = 0; i < 96; i++) begin
                slot(2, q_req, q_addr);
                if (i == 0 && ln < 4) check_val($sformatf("m1_line%0d", ln), q_addr, 16'h0400);
                if (i == 0 && ln == 4) check_val("m1_line4", q_addr, 16'h0420);
                if (ln == 4 && i == 2) break;
            end
            if (ln < 4) hsync(1'b0);
        end

        // Slow memory: the second slot lands while the first read is still pending.
        frame(7'h02, 3'b101);
        ack_dly = 6;
        slot(3, q_req, q_addr);
        slot(3, q_req, q_addr);
        check_val("ovr_set", 16'(Overrun), 16'h0001);
        for (int i = 0; i < 6; i++) slot(3, q_req, q_addr);
        ack_dly = 0;
        mem_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        frame(7'h02, 3'b101);
        check_val("ovr_clr", 16'(Overrun), 16'h0000);

        // Alpha mode: RPn high at the fifth hfall.
        frame(7'h02, 3'b000);
        for (int ln = 1; ln <= 13; ln++) begin
            slot(2, q_req, q_addr);
            if (ln == 6) check_val("rp_line6", q_addr, RP_SYNC ? 16'h0404 : 16'h0400);
            if (ln == 13) check_val("rp_line13", q_addr, 16'h0404);
            for (int i = 0; i < 3; i++) slot(2, q_req, q_addr);
            hsync(ln == 5);
        end

        // Wrap from 0xFFFF to 0x0000.
        frame(7'h7F, 3'b101);
        for (int i = 0; i < 520; i++) begin
            slot(2, q_req, q_addr);
            if (i == 511) check_val("wrap_top", q_addr, 16'hFFFF);
            if (i == 512) check_val("wrap_zero", q_addr, 16'h0000);
        end

        for (int it = 0; it < 600; it++) begin
            int r;
            r = $urandom_range(0, 19);
            ack_dly = $urandom_range(0, 3);
            if (r == 0)      frame(7'($urandom), 3'($urandom));
            else if (r < 3)  hsync(1'($urandom_range(0, 1)));
            else             slot($urandom_range(0, 4), q_req, q_addr);
        end

        // Reset lands while a request is outstanding.
        ack_dly = 0;
        frame(7'h02, 3'b101);
        for (int i = 0; i < 16; i++) slot(2, q_req, q_addr);
        ack_dly = 1000;
        slot(0, q_req, q_addr);
        check_val("pre_rst_req", 16'(q_req), 16'h0001);
        check_val("pre_rst_addr", q_addr, 16'h0410);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("async_rst", 1'b0, 16'h0000, 8'h00, 1'b0);
        model_reset();
        ack_dly = 0;
        @(negedge Clk);
        Reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, cur_base, cur_vmode, 1'b1, 8'hFF);
        checkOutput("late_ack", 1'b0, 16'h0000, 8'h00, 1'b0);
        slot(2, q_req, q_addr);
        check_val("post_rst_req", 16'(q_req), 16'h0001);
        check_val("post_rst_addr", q_addr, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
